vga_scan_gen: RTL and testbench

//  Upstream scan stage for the 16x16 sprite/mask ROMs: generates 640x480@60 VGA timing,

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/pix_tick_div.sv | 50 +++++
 rtl/vga_scan_gen.sv | 139 +++++++++++++
 tb/tb_vga_scan_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Package: vga_timing_pkg
// Shared 640x480@60 VGA timing for the scan generator and anything that
// consumes its coordinates.
//   H_* / V_*   : visible, front porch, sync and back porch widths
//   H_TOTAL     : pixels per line (800)
//   V_TOTAL     : lines per frame (525)
//   SYNC_POL    : level of hsync/vsync during the sync pulse (active-low)
//   coord_t     : 10-bit pixel coordinate, wide enough for 0..799
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic SYNC_POL = 1'b0;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/pix_tick_div.sv
// Module: pix_tick_div
// Divides clk down to the pixel rate. The divider counts 0..CLK_DIV-1 while
// en is high and pix_tick is high for the clk in which the count equals
// CLK_DIV-1. With en low the count holds and pix_tick is forced low, so the
// phase is preserved across a pause.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   en       in  enable; low freezes the divider
//   pix_tick out one-clk pixel strobe
//   div_cnt  out current divider count (debug visibility)
module pix_tick_div
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     en,
  output logic                                     pix_tick,
  output logic [((CLK_DIV > 1) ? $clog2(CLK_DIV) : 1)-1:0] div_cnt
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          tick_q;

  always_comb begin
    cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // tick_q mirrors (cnt == LAST) but is a register, so it reads 0 during
  // reset even when CLK_DIV=1 (where the count is permanently LAST).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else if (en) begin
      cnt    <= cnt_nxt;
      tick_q <= (cnt_nxt == LAST);
    end
  end

  assign pix_tick = tick_q & en;
  assign div_cnt  = cnt;

endmodule

// File: rtl/vga_scan_gen.sv
// Module: vga_scan_gen
// Scan stage feeding the 16x16 sprite/mask ROMs. Generates VGA timing, the
// pixel coordinates px/py, and sync/video_on delayed by PIPE_DLY pixels so
// they line up with colour from the downstream ROM/mux pipeline.
// Optional feature macro: VGA_FRAME_CNT_EN adds the 8-bit frame_cnt port.
// Parameters:
//   CLK_DIV  clk cycles per pixel (>=1)
//   PIPE_DLY pixel delay on hsync/vsync/video_on (0..3)
//   HA/HF/HS/HB, VA/VF/VS/VB  timing widths, default to vga_timing_pkg
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           scan enable; low freezes the whole block
//   pix_tick     one-clk strobe on which the counters advance
//   px, py       horizontal / vertical counters
//   video_on     active-area flag (delayed)
//   hsync, vsync active-low syncs (delayed)
//   frame_start  one-clk pulse when (px,py) becomes (0,0)
//   frame_cnt    frame counter mod 256 (VGA_FRAME_CNT_EN only)
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int PIPE_DLY = 1,
  parameter int HA = H_ACTIVE,
  parameter int HF = H_FP,
  parameter int HS = H_SYNC,
  parameter int HB = H_BP,
  parameter int VA = V_ACTIVE,
  parameter int VF = V_FP,
  parameter int VS = V_SYNC,
  parameter int VB = V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_tick,
  output coord_t     px,
  output coord_t     py,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
`ifdef VGA_FRAME_CNT_EN
  output logic       frame_start,
  output logic [7:0] frame_cnt
`else
  output logic       frame_start
`endif
);

  localparam coord_t H_LAST   = coord_t'(HA + HF + HS + HB - 1);
  localparam coord_t V_LAST   = coord_t'(VA + VF + VS + VB - 1);
  localparam coord_t HS_FIRST = coord_t'(HA + HF);
  localparam coord_t HS_LAST  = coord_t'(HA + HF + HS - 1);
  localparam coord_t VS_FIRST = coord_t'(VA + VF);
  localparam coord_t VS_LAST  = coord_t'(VA + VF + VS - 1);
  // Idle value of {hsync, vsync, video_on}
  localparam logic [2:0] IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          wrap;
  logic          fs_q;
  logic          hs_r, vs_r, vid_r;
  logic [2:0]    raw;

  pix_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .pix_tick (pix_tick),
    .div_cnt  (div_cnt)
  );

  assign wrap = (px == H_LAST) && (py == V_LAST);

  // pix_tick is already gated by en, so the counters hold while paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px <= '0;
      py <= '0;
    end else if (pix_tick) begin
      if (px == H_LAST) begin
        px <= '0;
        py <= (py == V_LAST) ? '0 : py + coord_t'(1);
      end else begin
        px <= px + coord_t'(1);
      end
    end
  end

  // Registered alongside the wrap so the pulse coincides with (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_q <= 1'b0;
    end else if (en) begin
      fs_q <= pix_tick && wrap;
    end
  end

  assign frame_start = fs_q & en;

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
    end else if (pix_tick && wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

  always_comb begin
    vid_r = (px < coord_t'(HA)) && (py < coord_t'(VA));
    hs_r  = ((px >= HS_FIRST) && (px <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vs_r  = ((py >= VS_FIRST) && (py <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    raw   = {hs_r, vs_r, vid_r};
  end

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign {hsync, vsync, video_on} = raw;
    end else begin : g_dly
      logic [2:0] pipe [PIPE_DLY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DLY; i++) pipe[i] <= IDLE;
        end else if (pix_tick) begin
          pipe[0] <= raw;
          for (int i = 1; i < PIPE_DLY; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign {hsync, vsync, video_on} = pipe[PIPE_DLY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_scan_gen.sv
// Testbench for vga_scan_gen. Three instances share clk/rst_n/en:
//   dut_a : default timing, CLK_DIV=2, PIPE_DLY=1
//   dut_c : default timing, CLK_DIV=2, PIPE_DLY=0
//   dut_b : shrunken timing (15x8 frame), CLK_DIV=1, PIPE_DLY=0, used for
//           vsync, frame wrap and frame_start checks within a short run.
// edge_n counts rising edges since the last reset release; outputs are
// sampled 1 time unit after each rising edge.
module tb_vga_scan_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;

  logic   a_tick, a_vid, a_hs, a_vs, a_fs;
  coord_t a_px, a_py;
  logic   c_tick, c_vid, c_hs, c_vs, c_fs;
  coord_t c_px, c_py;
  logic   b_tick, b_vid, b_hs, b_vs, b_fs;
  coord_t b_px, b_py;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] a_fc, c_fc, b_fc;
`endif

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  vga_scan_gen #(.CLK_DIV(2), .PIPE_DLY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(a_tick), .px(a_px), .py(a_py),
    .video_on(a_vid), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  vga_scan_gen #(.CLK_DIV(2), .PIPE_DLY(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(c_tick), .px(c_px), .py(c_py),
    .video_on(c_vid), .hsync(c_hs), .vsync(c_vs), .frame_start(c_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(c_fc)
`endif
  );

  vga_scan_gen #(.CLK_DIV(1), .PIPE_DLY(0),
                 .HA(8), .HF(2), .HS(3), .HB(2),
                 .VA(4), .VF(1), .VS(2), .VB(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(b_tick), .px(b_px), .py(b_py),
    .video_on(b_vid), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

  // Scoreboard check: one immediate assertion per comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) step(1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    // Reset state
    step(3);
    check("rst_px", a_px, 0);
    check("rst_py", a_py, 0);
    check("rst_tick", a_tick, 0);
    check("rst_vid", a_vid, 0);
    check("rst_hs", a_hs, 1);
    check("rst_vs", a_vs, 1);
    check("rst_fs", a_fs, 0);
`ifdef VGA_FRAME_CNT_EN
    check("rst_fc", a_fc, 0);
`endif

    // First pix_tick timing
    release_reset();
    check("rel_tick0", a_tick, 0);
    run_to(1);
    check("e1_tick", a_tick, 1);
    check("e1_px", a_px, 0);
    check("e1_vid_idle", a_vid, 0);
    run_to(2);
    check("e2_tick", a_tick, 0);
    check("e2_px", a_px, 1);
    check("e2_vid", a_vid, 1);

    // video_on edge at px=640, undelayed vs delayed
    run_to(1278);
    check("c_px639", c_px, 639);
    check("c_vid_639", c_vid, 1);
    run_to(1280);
    check("a_px640", a_px, 640);
    check("c_vid_640", c_vid, 0);
    check("a_vid_640", a_vid, 1);
    run_to(1282);
    check("a_vid_641", a_vid, 0);

    // hsync pulse px 656..751
    run_to(1310);
    check("c_hs_655", c_hs, 1);
    run_to(1312);
    check("c_hs_656", c_hs, 0);
    check("a_hs_656", a_hs, 1);
    run_to(1314);
    check("a_hs_657", a_hs, 0);
    run_to(1502);
    check("c_px751", c_px, 751);
    check("c_hs_751", c_hs, 0);
    run_to(1504);
    check("c_hs_752", c_hs, 1);
    check("a_hs_752", a_hs, 0);
    run_to(1506);
    check("a_hs_753", a_hs, 1);

    // Line wrap after 1600 clks
    run_to(1598);
    check("a_px799", a_px, 799);
    check("a_py_l0", a_py, 0);
    run_to(1600);
    check("a_px_wrap", a_px, 0);
    check("a_py_l1", a_py, 1);
    check("a_fs_l1", a_fs, 0);

    // Pause at px=300 in the tick phase
    run_to(2201);
    check("pre_px300", a_px, 300);
    check("pre_tick", a_tick, 1);
    en = 1'b0;
    #1;
    check("en0_tick", a_tick, 0);
    step(37);
    check("frz_px", a_px, 300);
    check("frz_py", a_py, 1);
    check("frz_tick", a_tick, 0);
    check("frz_hs", a_hs, 1);
    check("frz_vs", a_vs, 1);
    en = 1'b1;
    #1;
    check("res_tick", a_tick, 1);
    check("res_px_hold", a_px, 300);
    step(1);
    check("res_px301", a_px, 301);

    // Reset pulse mid-line
    step(198);
    check("pre_rst_px400", a_px, 400);
    rst_n = 1'b0;
    #1;
    check("mid_rst_px", a_px, 0);
    check("mid_rst_py", a_py, 0);
    check("mid_rst_tick", a_tick, 0);
    check("mid_rst_vid", a_vid, 0);
    check("mid_rst_hs", a_hs, 1);
    check("mid_rst_vs", a_vs, 1);
    check("mid_rst_fs", a_fs, 0);
    check("mid_rst_bpx", b_px, 0);
`ifdef VGA_FRAME_CNT_EN
    check("mid_rst_bfc", b_fc, 0);
`endif
    step(2);
    release_reset();

    // Shrunken frame: 15 px x 8 lines, one tick per clk
    run_to(1);
    check("b_e1_tick", b_tick, 1);
    check("b_e1_px", b_px, 0);
    check("b_e1_fs", b_fs, 0);
    run_to(8);
    check("b_vid_7", b_vid, 1);
    run_to(9);
    check("b_vid_8", b_vid, 0);
    run_to(10);
    check("b_hs_9", b_hs, 1);
    run_to(11);
    check("b_hs_10", b_hs, 0);
    run_to(13);
    check("b_hs_12", b_hs, 0);
    run_to(14);
    check("b_hs_13", b_hs, 1);
    run_to(75);
    check("b_py4", b_py, 4);
    check("b_vs_l4", b_vs, 1);
    run_to(76);
    check("b_py5", b_py, 5);
    check("b_vs_l5", b_vs, 0);
    run_to(105);
    check("b_vs_l6", b_vs, 0);
    run_to(106);
    check("b_py7", b_py, 7);
    check("b_vs_l7", b_vs, 1);
    run_to(120);
    check("b_px14", b_px, 14);
    check("b_fs_pre", b_fs, 0);
    run_to(121);
    check("b_wrap_px", b_px, 0);
    check("b_wrap_py", b_py, 0);
    check("b_fs_1", b_fs, 1);
`ifdef VGA_FRAME_CNT_EN
    check("b_fc_1", b_fc, 1);
`endif
    run_to(122);
    check("b_fs_width", b_fs, 0);
    run_to(240);
    check("b_fs2_pre", b_fs, 0);
    run_to(241);
    check("b_fs2", b_fs, 1);
    check("a_fs_none", a_fs, 0);
    run_to(361);
    check("b_fs3", b_fs, 1);
`ifdef VGA_FRAME_CNT_EN
    check("b_fc_3", b_fc, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
